// File: rtl/sensor_reset_pkg.sv
// -----------------------------------------------------------------------------
// sensor_reset_pkg
// Shared constants for the sensor reset controller: the Avalon-MM register map
// word addresses and the value the pulse-length register takes out of reset.
// -----------------------------------------------------------------------------
package sensor_reset_pkg;

    // Register map (word addresses on the 3-bit slave address bus)
    localparam logic [2:0] ADDR_LEVEL = 3'd0;  // R/W  steady per-channel level
    localparam logic [2:0] ADDR_SET   = 3'd1;  // W1S  reads back as LEVEL
    localparam logic [2:0] ADDR_CLEAR = 3'd2;  // W1C  reads back as LEVEL, aborts pulses
    localparam logic [2:0] ADDR_PULSE = 3'd3;  // W1   pulse trigger, reads 0
    localparam logic [2:0] ADDR_LEN   = 3'd4;  // R/W  pulse length in cycles
    localparam logic [2:0] ADDR_BUSY  = 3'd5;  // RO   per-channel pulse running

    // Pulse length after reset
    localparam int LEN_DEFAULT = 1;

endpackage

// File: rtl/sensor_reset_pulse_ch.sv
// -----------------------------------------------------------------------------
// sensor_reset_pulse_ch
// One channel's pulse-length down-counter.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset, clears the counter
//   load       start (or restart) a pulse of max(len,1) cycles
//   abort      stop any running pulse; wins over load
//   len        pulse length in cycles (0 is treated as 1)
//   busy       counter is nonzero this cycle
//   busy_next  counter will be nonzero next cycle; lets the parent register
//              its output from next-state values so the pulse appears at the
//              output the cycle right after the trigger write
// -----------------------------------------------------------------------------
module sensor_reset_pulse_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             abort,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             busy_next
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // A reload replaces the remaining count rather than adding to it, so a
    // retrigger restarts the full length.
    always_comb begin
        cnt_next = cnt;
        if (abort) begin
            cnt_next = '0;
        end else if (load) begin
            cnt_next = (len == '0) ? CNT_W'(1) : len;
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign busy      = (cnt != '0);
    assign busy_next = (cnt_next != '0);

endmodule

// File: rtl/sensor_reset_ctrl.sv
// -----------------------------------------------------------------------------
// sensor_reset_ctrl
// Avalon-MM controlled bank of sensor reset outputs. Each channel can be held
// active by a software level bit, or driven active for a programmable number
// of cycles by a pulse trigger. Outputs are registered and optionally
// active-low per channel.
//
// Parameters
//   NUM_CH       number of channels (1..32)
//   CNT_W        pulse-length counter width (1..31)
//   RESET_VALUE  power-on value of the level register
//   OUT_INVERT   per-channel mask; 1 makes that out_port bit active-low
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   address     slave word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data (latency 0, no waitrequest)
//   out_port    registered per-channel reset outputs
// -----------------------------------------------------------------------------
module sensor_reset_ctrl
    import sensor_reset_pkg::*;
#(
    parameter int                NUM_CH      = 8,
    parameter int                CNT_W       = 16,
    parameter logic [NUM_CH-1:0] RESET_VALUE = '0,
    parameter logic [NUM_CH-1:0] OUT_INVERT  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port
);

    logic              wr;
    logic [NUM_CH-1:0] wd;
    logic [CNT_W-1:0]  wd_len;

    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] level_next;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  len_next;

    logic [NUM_CH-1:0] load_vec;
    logic [NUM_CH-1:0] abort_vec;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] busy_next;

    // Upper writedata bits are ignored for narrow configurations.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wr     = chipselect & ~write_n;
    assign wd     = writedata[NUM_CH-1:0];
    assign wd_len = writedata[CNT_W-1:0];

    // Bus write decode
    always_comb begin
        level_next = level;
        len_next   = len;
        load_vec   = '0;
        abort_vec  = '0;
        if (wr) begin
            case (address)
                ADDR_LEVEL: level_next = wd;
                ADDR_SET:   level_next = level | wd;
                ADDR_CLEAR: begin
                    level_next = level & ~wd;
                    abort_vec  = wd;
                end
                ADDR_PULSE: load_vec   = wd;
                ADDR_LEN:   len_next   = wd_len;
                default:    ;
            endcase
        end
    end

    // Per-channel pulse counters
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sensor_reset_pulse_ch #(
            .CNT_W (CNT_W)
        ) u_pulse_ch (
            .clk       (clk),
            .reset     (reset),
            .load      (load_vec[i]),
            .abort     (abort_vec[i]),
            .len       (len),
            .busy      (busy[i]),
            .busy_next (busy_next[i])
        );
    end

    // Register stage: out_port is registered from the next-state active
    // vector so it tracks level|busy of the same cycle, one edge after the
    // write that changed them.
    always_ff @(posedge clk) begin
        if (reset) begin
            level    <= RESET_VALUE;
            len      <= CNT_W'(LEN_DEFAULT);
            out_port <= RESET_VALUE ^ OUT_INVERT;
        end else begin
            level    <= level_next;
            len      <= len_next;
            out_port <= (level_next | busy_next) ^ OUT_INVERT;
        end
    end

    // Read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_LEVEL, ADDR_SET, ADDR_CLEAR: readdata[NUM_CH-1:0] = level;
            ADDR_LEN:                         readdata[CNT_W-1:0]  = len;
            ADDR_BUSY:                        readdata[NUM_CH-1:0] = busy;
            default:                          readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sensor_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sensor_reset_ctrl
// Directed stimulus with a cycle-tagged scoreboard: stimulus pushes expected
// out_port / readdata values tagged with the cycle they must appear in, and an
// independent monitor compares them on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sensor_reset_ctrl;

    localparam int          NUM_CH = 8;
    localparam int          CNT_W  = 16;
    localparam logic [7:0]  RV     = 8'h01;
    localparam logic [7:0]  INV    = 8'h80;

    localparam logic [2:0] A_LEVEL = 3'd0;
    localparam logic [2:0] A_SET   = 3'd1;
    localparam logic [2:0] A_CLEAR = 3'd2;
    localparam logic [2:0] A_PULSE = 3'd3;
    localparam logic [2:0] A_LEN   = 3'd4;
    localparam logic [2:0] A_BUSY  = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    sensor_reset_ctrl #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .RESET_VALUE (RV),
        .OUT_INVERT  (INV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        bit          sel;    // 0: out_port, 1: readdata
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Insert keeping the queue ordered by target cycle.
    task automatic push(input int at, input bit sel, input logic [31:0] exp,
                        input string name);
        exp_t e;
        int   idx;
        e.at = at; e.sel = sel; e.exp = exp; e.name = name;
        idx = q.size();
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].at > at) begin
                idx = k;
                break;
            end
        end
        q.insert(idx, e);
    endtask

    // Monitor
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            checks++;
            act = e.sel ? readdata : {24'h0, out_port};
            if (e.at < cyc) begin
                errors++;
                $display("FAIL %s: check missed, due cycle %0d now %0d", e.name, e.at, cyc);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL %s at cycle %0d: got %h expected %h", e.name, cyc, act, e.exp);
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            chipselect = 1'b0;
            write_n    = 1'b1;
            address    = A_BUSY;
            writedata  = '0;
            @(posedge clk); #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = A_BUSY;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        push(cyc, 1'b1, exp, name);
        @(posedge clk); #1;
        chipselect = 1'b0;
        address    = A_BUSY;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        int t2;
        reset      = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_LEVEL;
        writedata  = 32'hFF;   // must lose against reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Reset state
        push(cyc, 1'b0, 32'h81, "reset_out_port");
        rd(A_LEVEL, 32'h01, "reset_level");
        rd(A_LEN,   32'h01, "reset_len");
        rd(A_BUSY,  32'h00, "reset_busy");

        // Basic pulse, LEN=5
        wr(A_LEN, 32'd5);
        t = cyc;
        for (int k = 1; k <= 5; k++) begin
            push(t + k, 1'b0, 32'h85, "pulse_out");
            push(t + k, 1'b1, 32'h04, "pulse_busy");
        end
        push(t + 6, 1'b0, 32'h81, "pulse_end_out");
        push(t + 6, 1'b1, 32'h00, "pulse_end_busy");
        push(t, 1'b1, 32'h00, "pulse_reads_zero");
        wr(A_PULSE, 32'h04);
        idle(7);

        // Retrigger at T+3 restarts the full length
        t = cyc;
        for (int k = 1; k <= 8; k++) push(t + k, 1'b0, 32'h85, "retrig_out");
        push(t + 9, 1'b0, 32'h81, "retrig_end_out");
        wr(A_PULSE, 32'h04);
        idle(2);
        t2 = cyc;
        if (t2 != t + 3) begin
            errors++;
            $display("FAIL retrig_timing: second write at %0d expected %0d", t2, t + 3);
        end
        wr(A_PULSE, 32'h04);
        idle(7);

        // CLEAR aborts a running pulse
        t = cyc;
        push(t + 1, 1'b0, 32'h85, "clr_out_run");
        push(t + 2, 1'b0, 32'h85, "clr_out_run");
        push(t + 1, 1'b1, 32'h04, "clr_busy_run");
        push(t + 2, 1'b1, 32'h01, "clr_reads_level");
        push(t + 3, 1'b0, 32'h81, "clr_out_abort");
        push(t + 3, 1'b1, 32'h00, "clr_busy_abort");
        push(t + 4, 1'b0, 32'h81, "clr_out_stays");
        wr(A_PULSE, 32'h04);
        idle(1);
        wr(A_CLEAR, 32'h04);
        idle(4);

        // SET leaves a running pulse alone
        t = cyc;
        for (int k = 1; k <= 7; k++) push(t + k, 1'b0, 32'h85, "set_out");
        for (int k = 3; k <= 5; k++) push(t + k, 1'b1, 32'h04, "set_busy_run");
        push(t + 6, 1'b1, 32'h00, "set_busy_end");
        wr(A_PULSE, 32'h04);
        idle(1);
        wr(A_SET, 32'h04);
        idle(5);
        wr(A_CLEAR, 32'h04);
        push(cyc, 1'b0, 32'h81, "set_restore_out");
        idle(1);

        // Level register ops and LEN=0
        wr(A_LEVEL, 32'h10);
        wr(A_SET,   32'h03);
        wr(A_CLEAR, 32'h01);
        rd(A_LEVEL, 32'h12, "level_rd0");
        rd(A_SET,   32'h12, "level_rd1");
        rd(A_CLEAR, 32'h12, "level_rd2");
        push(cyc, 1'b0, 32'h92, "level_out");
        wr(A_LEN, 32'd0);
        rd(A_LEN, 32'h00, "len_zero_rd");
        t = cyc;
        push(t + 1, 1'b0, 32'h93, "len0_out_on");
        push(t + 1, 1'b1, 32'h01, "len0_busy_on");
        push(t + 2, 1'b0, 32'h92, "len0_out_off");
        push(t + 2, 1'b1, 32'h00, "len0_busy_off");
        wr(A_PULSE, 32'h01);
        idle(3);
        wr(3'd7, 32'hFF);
        rd(3'd6,    32'h00, "addr6_rd");
        rd(3'd7,    32'h00, "addr7_rd");
        rd(A_LEVEL, 32'h12, "addr7_write_ignored");

        // Reset mid-pulse
        wr(A_LEN, 32'd100);
        rd(A_LEN, 32'h64, "len100_rd");
        t = cyc;
        for (int k = 1; k <= 3; k++) push(t + k, 1'b0, 32'h96, "rst_pulse_out");
        push(t + 3, 1'b1, 32'h04, "rst_pulse_busy");
        push(t + 4, 1'b0, 32'h81, "rst_out_reset_value");
        wr(A_PULSE, 32'h04);
        idle(2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rd(A_BUSY,  32'h00, "rst_busy");
        rd(A_LEVEL, 32'h01, "rst_level");
        rd(A_LEN,   32'h01, "rst_len");
        idle(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_reset_ctrl.md
SENSOR_RESET_CTRL -- requirements
Module: sensor_reset_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8: number of sensor reset channels, legal range 1..32.
REQ-002 Parameter CNT_W, default 16: pulse-length counter width, legal range 1..31.
REQ-003 Parameter RESET_VALUE, default 0: NUM_CH-bit power-on value of the level register.
REQ-004 Parameter OUT_INVERT, default 0: NUM_CH-bit mask; a 1 makes that out_port bit active-low.
REQ-005 clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  3  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data; combinational, read latency 0, no waitrequest.
REQ-012 out_port  output  NUM_CH  per-channel sensor reset outputs, registered.

Function
REQ-013 A write occurs in a cycle when chipselect=1 and write_n=0; only writedata[NUM_CH-1:0] is used, except at LEN.
REQ-014 Register map: 0 LEVEL (R/W), 1 SET (W1S, reads as LEVEL), 2 CLEAR (W1C, reads as LEVEL), 3 PULSE (W1 trigger, reads 0), 4 LEN (R/W, CNT_W bits), 5 BUSY (RO); addresses 6 and 7 read 0 and ignore writes.
REQ-015 LEVEL write: level <= writedata; SET: level <= level | wd; CLEAR: level <= level & ~wd.
REQ-016 A CLEAR write also aborts any active pulse on each channel whose wd bit is 1; that channel's counter is 0 on the next cycle.
REQ-017 PULSE write: for each wd bit that is 1, load that channel's counter with max(LEN,1).
REQ-018 Each nonzero counter decrements by 1 per cycle; busy[i] = (cnt[i] != 0).
REQ-019 Active state of channel i is level[i] | busy[i].
REQ-020 out_port[i] <= active[i] ^ OUT_INVERT[i]; out_port is registered.
REQ-021 Timing: a PULSE write in cycle T drives channel i active at out_port from T+1 to T+max(LEN,1) inclusive, then inactive unless level[i]=1.
REQ-022 A PULSE write to a busy channel reloads its counter, restarting the full length; the pulse does not stretch by the remaining count.
REQ-023 A LEVEL or SET write never cancels an active pulse.
REQ-024 Changing LEN does not affect counters already running.
REQ-025 LEN=0 is treated as length 1.
REQ-026 readdata[31:NUM_CH] reads 0 for the LEVEL, SET, CLEAR and BUSY addresses.
REQ-027 readdata[31:CNT_W] reads 0 for the LEN address.
REQ-028 BUSY reads busy[NUM_CH-1:0] for the current cycle.

Reset
REQ-029 While reset=1 at a clk edge: level <= RESET_VALUE, all counters <= 0, LEN <= 1.
REQ-030 While reset=1 at a clk edge: out_port <= RESET_VALUE ^ OUT_INVERT.
REQ-031 Reset takes priority over a simultaneous bus write.
REQ-032 Reset asserted during an active pulse terminates the pulse at the next clk edge.

Structure
REQ-033 Package sensor_reset_pkg holds the address constants ADDR_LEVEL..ADDR_BUSY and the default LEN value.
REQ-034 One sub-module, sensor_reset_pulse_ch, implements one channel's counter: inputs load, abort, len; output busy.
REQ-035 sensor_reset_ctrl instantiates sensor_reset_pulse_ch NUM_CH times through a generate loop.

Verification
REQ-036 Reset with RESET_VALUE=8'h01, OUT_INVERT=8'h80 -> out_port=8'h81, then LEVEL=1, LEN=1, BUSY=0.
REQ-037 Write LEN=5, then PULSE=8'h04 in cycle T -> out_port[2]=1 during T+1..T+5, 0 at T+6; BUSY[2]=1 while the pulse runs.
REQ-038 Write PULSE=8'h04 at T (LEN=5), again at T+3 -> out_port[2] stays high continuously through T+8 and falls at T+9.
REQ-039 Pulse active on ch2, write CLEAR=8'h04 at T+2 -> out_port[2]=0 from T+3 and BUSY[2]=0; a SET=8'h04 instead leaves the pulse running.
REQ-040 Write LEVEL=8'h10, SET=8'h03, CLEAR=8'h01 -> readback of address 0 gives 8'h12; writing LEN=0 then PULSE=8'h01 gives exactly a 1-cycle pulse.
REQ-041 Assert reset mid-pulse with LEN=100 -> out_port returns to the reset value on the next edge, and a later read of BUSY returns 0.
